// File: rtl/apb_clkdiv_gen.sv
// Counter-based clock divider fed by the APB divider register block; divisor updates land on period boundaries.
// Optional status outputs (active divisor, pending flag) are enabled with `define APB_CLKDIV_GEN_STATUS_EN.
module apb_clkdiv_gen #(
    parameter int                   DIV_WIDTH = 8,
    parameter logic [DIV_WIDTH-1:0] DIV_RESET = '0
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 div_valid_i,
    output logic                 div_ack_o,
    output logic                 clk_o,
`ifdef APB_CLKDIV_GEN_STATUS_EN
    output logic [DIV_WIDTH-1:0] active_div_o,
    output logic                 pending_o,
`endif
    output logic                 tick_o
);

    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_pend;
    logic                 r_pv;
    logic                 r_clk;
    logic                 r_tick;
    logic                 r_ack;

    logic [DIV_WIDTH-1:0] w_eff;
    logic                 w_boundary;
    logic [DIV_WIDTH-1:0] w_nextDiv;
    logic [DIV_WIDTH-1:0] w_nextCnt;
    logic [DIV_WIDTH-1:0] w_nextPend;
    logic                 w_nextPv;
    logic                 w_nextAck;
    logic [DIV_WIDTH-1:0] w_nextEff;
    logic [DIV_WIDTH-1:0] w_nextHighStart;
    logic                 w_nextClk;
    logic                 w_nextTick;

    // Next-state logic; outputs are derived from the next cnt/N so they line up with the registered cnt.
    always_comb begin
        w_eff      = (r_div == DIV_WIDTH'(1)) ? DIV_WIDTH'(2) : r_div;
        w_boundary = (r_div != '0) && (r_cnt == w_eff - DIV_WIDTH'(1));
        w_nextDiv  = r_div;
        w_nextCnt  = r_cnt;
        w_nextPend = r_pend;
        w_nextPv   = r_pv;
        w_nextAck  = 1'b0;

        if (r_div == '0) begin
            if (div_valid_i) begin
                w_nextDiv = div_i;
                w_nextCnt = '0;
                w_nextPv  = 1'b0;
                w_nextAck = 1'b1;
            end
        end else if (w_boundary) begin
            w_nextCnt = '0;
            if (div_valid_i || r_pv) begin
                w_nextDiv = div_valid_i ? div_i : r_pend;
                w_nextPv  = 1'b0;
                w_nextAck = 1'b1;
            end
        end else begin
            w_nextCnt = r_cnt + DIV_WIDTH'(1);
            if (div_valid_i) begin
                w_nextPend = div_i;
                w_nextPv   = 1'b1;
            end
        end

        w_nextEff       = (w_nextDiv == DIV_WIDTH'(1)) ? DIV_WIDTH'(2) : w_nextDiv;
        w_nextHighStart = w_nextEff - (w_nextEff >> 1);
        w_nextClk       = (w_nextDiv != '0) && (w_nextCnt >= w_nextHighStart);
        w_nextTick      = (w_nextDiv != '0) && (w_nextCnt == w_nextHighStart);
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_div  <= DIV_RESET;
            r_cnt  <= '0;
            r_pend <= '0;
            r_pv   <= 1'b0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
            r_ack  <= 1'b0;
        end else begin
            r_div  <= w_nextDiv;
            r_cnt  <= w_nextCnt;
            r_pend <= w_nextPend;
            r_pv   <= w_nextPv;
            r_clk  <= w_nextClk;
            r_tick <= w_nextTick;
            r_ack  <= w_nextAck;
        end
    end

    assign clk_o     = r_clk;
    assign tick_o    = r_tick;
    assign div_ack_o = r_ack;
`ifdef APB_CLKDIV_GEN_STATUS_EN
    assign active_div_o = r_div;
    assign pending_o    = r_pv;
`endif

endmodule

// File: tb/tb_apb_clkdiv_gen.sv
// Bench for apb_clkdiv_gen: directed scenarios then random strobes/resets against a period-timeline model.
module tb_apb_clkdiv_gen;

    localparam int         W     = 8;
    localparam logic [7:0] RSTDV = 8'd10;

    logic         HCLK = 1'b0;
    logic         HRESETn;
    logic [W-1:0] div_i;
    logic         div_valid_i;
    logic         div_ack_o;
    logic         clk_o;
    logic         tick_o;
`ifdef APB_CLKDIV_GEN_STATUS_EN
    logic [W-1:0] active_div_o;
    logic         pending_o;
`endif

    int errorCount = 0;
    int checkCount = 0;

    // Model: divisor in force, the cycle index at which its current period began, and the pending write.
    int mDiv;
    int periodStart;
    int cycleIdx;
    int pendVal;
    bit pendFlag;
    bit expAck;

    apb_clkdiv_gen #(.DIV_WIDTH(W), .DIV_RESET(RSTDV)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .div_i       (div_i),
        .div_valid_i (div_valid_i),
        .div_ack_o   (div_ack_o),
        .clk_o       (clk_o),
`ifdef APB_CLKDIV_GEN_STATUS_EN
        .active_div_o(active_div_o),
        .pending_o   (pending_o),
`endif
        .tick_o      (tick_o)
    );

    always #5 HCLK = ~HCLK;

    function automatic int effPeriod(input int n);
        return (n == 1) ? 2 : n;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s cycle=%0d got=%0d expected=%0d", tag, cycleIdx, observed, expected);
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, then compare just after the edge.
    task automatic applyStimulus(input bit valid, input int d, input bit rstn);
        int elapsed;
        int e;
        int pos;
        bit expClk;
        bit expTick;
        HRESETn     = rstn;
        div_valid_i = valid;
        div_i       = W'(d);
        @(posedge HCLK);
        cycleIdx++;
        if (!rstn) begin
            mDiv = RSTDV; periodStart = cycleIdx; pendFlag = 0; pendVal = 0; expAck = 0;
        end else if (mDiv == 0) begin
            expAck = valid;
            if (valid) begin
                mDiv = d; periodStart = cycleIdx; pendFlag = 0;
            end
        end else begin
            elapsed = (cycleIdx - 1) - periodStart;
            expAck = 0;
            if (elapsed == effPeriod(mDiv) - 1) begin
                if (valid || pendFlag) begin
                    mDiv = valid ? d : pendVal;
                    pendFlag = 0;
                    expAck = 1;
                end
                periodStart = cycleIdx;
            end else if (valid) begin
                pendVal = d; pendFlag = 1;
            end
        end
        if (mDiv == 0) begin
            expClk = 0; expTick = 0;
        end else begin
            e = effPeriod(mDiv);
            pos = cycleIdx - periodStart;
            expClk  = (pos >= e - e / 2);
            expTick = (pos == e - e / 2);
        end
        #1;
        checkOutput("clk_o", clk_o, expClk);
        checkOutput("tick_o", tick_o, expTick);
        checkOutput("div_ack_o", div_ack_o, expAck);
`ifdef APB_CLKDIV_GEN_STATUS_EN
        checkOutput("active_div_o", active_div_o, mDiv);
        checkOutput("pending_o", pending_o, pendFlag);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 1);
    endtask

    initial begin
        mDiv = RSTDV; periodStart = 0; cycleIdx = 0; pendVal = 0; pendFlag = 0; expAck = 0;
        HRESETn = 1'b0; div_valid_i = 1'b0; div_i = '0;

        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0);
        idle(25);
        applyStimulus(1, 4, 1);
        idle(20);
        applyStimulus(1, 10, 1);
        idle(12);
        applyStimulus(1, 6, 1);
        idle(2);
        applyStimulus(1, 8, 1);
        idle(20);
        applyStimulus(1, 4, 1);
        idle(9);
        applyStimulus(1, 0, 1);
        idle(15);
        applyStimulus(1, 1, 1);
        idle(10);
        applyStimulus(1, 0, 1);
        idle(4);
        applyStimulus(1, 3, 1);
        idle(10);
        applyStimulus(1, 3, 1);
        idle(8);
        applyStimulus(0, 0, 0);
        idle(4);
        applyStimulus(1, 5, 1);
        idle(3);
        applyStimulus(0, 0, 0);
        idle(25);

        for (int i = 0; i < 4000; i++) begin
            bit v;
            bit r;
            int d;
            v = ($urandom_range(0, 14) == 0);
            r = ($urandom_range(0, 299) != 0);
            case ($urandom_range(0, 3))
                0: d = $urandom_range(0, 3);
                1: d = $urandom_range(0, 20);
                2: d = $urandom_range(0, 255);
                default: d = $urandom_range(4, 12);
            endcase
            applyStimulus(v, d, r);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
